sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl.sv | 139 +++++++++++++
 tb/tb_sram_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port SRAM with valid/ready request/response, byte masks, range check
// Optional post-reset zero-fill engine enabled by defining SRAM_CTRL_CLEAR_EN.
module sram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

`ifdef SRAM_CTRL_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_RUN;
`endif

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_wmask;

    logic             clearing;
    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] req_idx;

    assign clearing = (state_q == ST_CLEAR);
    assign req_idx  = req_addr[IDX_W-1:0];
    assign in_range = ({1'b0, req_addr} < DEPTH_W);

`ifdef SRAM_CTRL_CLEAR_EN
    assign busy = clearing;
`else
    assign busy = 1'b0;
`endif

    // rsp_ready feeds req_ready combinationally so a drained response frees the slot in the same cycle
    assign req_ready = !busy && rst_n && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + IDX_W'(1);
            if (clr_cnt_q == LAST_IDX) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = req_idx;
        mem_wdata = req_wdata;
        mem_wmask = req_wmask;
        if (clearing) begin
            mem_we    = rst_n;
            mem_idx   = clr_cnt_q;
            mem_wdata = '0;
            mem_wmask = '1;
        end else if (accept && req_we && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (accept && !req_we) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !in_range;
            rsp_rdata_d = in_range ? mem_q[req_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Array is deliberately outside the reset domain so it maps onto a plain SRAM macro
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wmask[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - scoreboard testbench for sram_ctrl (DEPTH=200 build)
module tb_sram_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 200;
`ifdef SRAM_CTRL_CLEAR_EN
    localparam int       CLR_CYCLES = DEPTH;
    localparam logic     BUSY_RST   = 1'b1;
`else
    localparam int       CLR_CYCLES = 0;
    localparam logic     BUSY_RST   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_wmask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    logic [DW-1:0] model [DEPTH];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   got_q [$];
    int total = 0;
    int bad   = 0;

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so the negedge view matches the next handshake edge
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) got_q.push_back({rsp_err, rsp_rdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [3:0] mask);
        int n = 0;
        int idx = int'(addr);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wmask = mask;
        #1;
        while (!req_ready && n < 400) begin
            tick(); #1; n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL send_accept addr=%0h req_ready=%b required 1", addr, req_ready);
        end else if (we) begin
            if (idx < DEPTH)
                for (int b = 0; b < 4; b++) if (mask[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            exp_q.push_back((idx < DEPTH) ? {1'b0, model[idx]} : {1'b1, 32'h0});
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic release_count(output int cycles, output bit ready_seen);
        cycles = 0; ready_seen = 0;
        rst_n = 1'b1;
        #1;
        while (busy && cycles < 1000) begin
            if (req_ready) ready_seen = 1;
            tick(); cycles++;
        end
    endtask

    task automatic test_reset();
        int cyc; bit rs;
        rst_n = 1'b0; rsp_ready = 1'b1;
        repeat (3) tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        total++; if (busy !== BUSY_RST) begin bad++; $display("FAIL rst_busy got=%b exp=%b", busy, BUSY_RST); end
        release_count(cyc, rs);
        total++; if (cyc != CLR_CYCLES) begin bad++; $display("FAIL clear_cycles got=%0d exp=%0d", cyc, CLR_CYCLES); end
        total++; if (rs !== 1'b0) begin bad++; $display("FAIL clear_ready_low got=%b exp=0", rs); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_clear_ready got=%b exp=1", req_ready); end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic test_clear_read();
        int n = 0;
        logic [DW:0] g, e;
`ifndef SRAM_CTRL_CLEAR_EN
        send(1'b1, 8'h55, 32'h0, 4'hF);
        send(1'b1, 8'd50, 32'h0, 4'hF);
        send(1'b1, 8'd122, 32'h0, 4'hF);
`endif
        send(1'b0, 8'h55, 32'h0, 4'h0);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL read_latency rsp_valid got=%b exp=1", rsp_valid); end
        total++; if ({rsp_err, rsp_rdata} !== 33'h0) begin bad++; $display("FAIL cleared_word got=%b/%h exp=0/0", rsp_err, rsp_rdata); end
        while (got_q.size() < exp_q.size() && n < 50) begin tick(); n++; end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL clr_rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL clr_rsp got=%h exp=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_raw_mask();
        int n = 0;
        logic [DW:0] g, e;
        send(1'b1, 8'h10, 32'hDEADBEEF, 4'b1111);
        send(1'b0, 8'h10, 32'h0, 4'h0);
        total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_data got=%h exp=deadbeef", rsp_rdata); end
        send(1'b1, 8'h10, 32'h11223344, 4'b0101);
        send(1'b0, 8'h10, 32'h0, 4'h0);
        total++; if (rsp_rdata !== 32'hDE22BE44) begin bad++; $display("FAIL mask_data got=%h exp=de22be44", rsp_rdata); end
        while (got_q.size() < exp_q.size() && n < 50) begin tick(); n++; end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL raw_rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL raw_rsp got=%h exp=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [DW:0] g, e;
        send(1'b1, 8'h11, 32'h0BADF00D, 4'hF);
        rsp_ready = 1'b0;
        send(1'b0, 8'h10, 32'h0, 4'h0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h11;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, req_ready); end
            total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44)
                begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/de22be44", i, rsp_valid, rsp_rdata); end
            tick(); #1;
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", req_ready); end
        exp_q.push_back({1'b0, model[8'h11]});
        tick();
        req_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D)
            begin bad++; $display("FAIL bp_second got=%b/%h exp=1/0badf00d", rsp_valid, rsp_rdata); end
        while (got_q.size() < exp_q.size() && n < 50) begin tick(); n++; end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL bp_rsp got=%h exp=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_out_of_range();
        int n = 0;
        logic [DW:0] g, e;
        send(1'b1, 8'd250, 32'hCAFEF00D, 4'hF);
        send(1'b0, 8'd250, 32'h0, 4'h0);
        total++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
            begin bad++; $display("FAIL oor_read got=%b/%h exp=1/0", rsp_err, rsp_rdata); end
        send(1'b0, 8'd50, 32'h0, 4'h0);
        total++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
            begin bad++; $display("FAIL alias_50 got=%b/%h exp=0/0", rsp_err, rsp_rdata); end
        send(1'b0, 8'd122, 32'h0, 4'h0);
        total++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
            begin bad++; $display("FAIL alias_122 got=%b/%h exp=0/0", rsp_err, rsp_rdata); end
        while (got_q.size() < exp_q.size() && n < 50) begin tick(); n++; end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL oor_rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL oor_rsp got=%h exp=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic [DW:0] g, e;
        for (int i = 0; i < 8; i++) send(1'b1, AW'(20 + i), $urandom, 4'hF);
        for (int i = 0; i < 8; i++) send(1'b1, AW'(20 + i), $urandom, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 8; i++) begin
            send(1'b0, AW'(20 + i), 32'h0, 4'h0);
            if (i == 3) send(1'b0, 8'd255, 32'h0, 4'h0);
        end
        send(1'b0, 8'd199, 32'h0, 4'h0);
        send(1'b0, 8'd200, 32'h0, 4'h0);
        while (got_q.size() < exp_q.size() && n < 50) begin tick(); n++; end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL b2b_rsp got=%h exp=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int cyc; bit rs;
        int n = 0;
        logic [DW:0] g, e;
        rsp_ready = 1'b0;
        send(1'b0, 8'h10, 32'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0)
            begin bad++; $display("FAIL mid_rst_rsp got=%b/%b exp=0/0", rsp_valid, rsp_err); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b1;
        tick();
`ifdef SRAM_CTRL_CLEAR_EN
        rst_n = 1'b1;
        repeat (100) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_midway_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL clear_rst got=%b/%b/%b exp=0/0/1", rsp_valid, rsp_err, busy); end
        tick();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
        release_count(cyc, rs);
        total++; if (cyc != CLR_CYCLES) begin bad++; $display("FAIL reclear_cycles got=%0d exp=%0d", cyc, CLR_CYCLES); end
        total++; if (rs !== 1'b0) begin bad++; $display("FAIL reclear_ready_low got=%b exp=0", rs); end
        send(1'b0, 8'h10, 32'h0, 4'h0);
        send(1'b0, 8'h11, 32'h0, 4'h0);
        while (got_q.size() < exp_q.size() && n < 50) begin tick(); n++; end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL mid_rsp got=%h exp=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_clear_read();
        test_raw_mask();
        test_backpressure();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
